// File: rtl/joystick_pkg.sv
// Shared constants for the Pmod joystick conditioner: line ordering, vector width and the
// debouncer state type.
package joystick_pkg;

    localparam int unsigned JOY_WIDTH = 5;

    // Line order; index 0 is the most significant bit of a joystick vector.
    localparam int unsigned JOY_FIRE  = 0;
    localparam int unsigned JOY_LEFT  = 1;
    localparam int unsigned JOY_RIGHT = 2;
    localparam int unsigned JOY_DOWN  = 3;
    localparam int unsigned JOY_UP    = 4;

    typedef enum logic {
        DbIdle,
        DbPending
    } db_state_e;

    // Bit position of a line within a descending [JOY_WIDTH-1:0] vector.
    function automatic int unsigned joy_pos(int unsigned idx);
        return JOY_WIDTH - 1 - idx;
    endfunction

endpackage

// File: rtl/joy_debounce_line.sv
// One joystick line: two-flop synchronizer followed by a tick-paced debouncer.
// The output is active-low like the pin and starts released after reset.
module joy_debounce_line
    import joystick_pkg::*;
#(
    parameter int unsigned DebounceTicks = 50
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic tick_i,
    input  logic pin_n_i,
    output logic stable_n_o
);

    localparam logic [7:0] CntLast = 8'(DebounceTicks - 1);

    logic       sync1_q, sync2_q;
    logic       stable_q, stable_d;
    logic [7:0] cnt_q, cnt_d;
    db_state_e  state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            state_q  <= DbIdle;
        end else begin
            sync1_q  <= pin_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        case (state_q)
            DbIdle: begin
                cnt_d = '0;
                if (sync2_q != stable_q) begin
                    state_d = DbPending;
                end
            end
            DbPending: begin
                if (sync2_q == stable_q) begin
                    state_d = DbIdle;
                    cnt_d   = '0;
                end else if (tick_i) begin
                    // Accept on the tick that finds the counter already at its last value.
                    if (cnt_q == CntLast) begin
                        stable_d = sync2_q;
                        cnt_d    = '0;
                        state_d  = DbIdle;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = DbIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign stable_n_o = stable_q;

endmodule

// File: rtl/joystick_conditioner.sv
// Conditions two raw active-low Pmod joystick ports into registered active-high vectors,
// with optional fire autofire, port swap and a one-cycle change strobe.
module joystick_conditioner
    import joystick_pkg::*;
#(
    parameter int unsigned Prescale      = 1074,
    parameter int unsigned DebounceTicks = 50,
    parameter int unsigned AutofireTicks = 3000
) (
    input  logic                 clk_i,
    input  logic                 rst_n,
    input  logic [JOY_WIDTH-1:0] pins1_n_i,
    input  logic [JOY_WIDTH-1:0] pins2_n_i,
    input  logic                 autofire_en_i,
    input  logic                 swap_i,
    output logic [JOY_WIDTH-1:0] joy1_o,
    output logic [JOY_WIDTH-1:0] joy2_o,
    output logic                 changed_o
);

    localparam int unsigned    PsW     = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam logic [PsW-1:0] PsLast  = PsW'(Prescale - 1);
    localparam logic [15:0]    AfLast  = 16'(AutofireTicks - 1);
    localparam int unsigned    FirePos = joy_pos(JOY_FIRE);
    localparam int unsigned    NLines  = 2 * JOY_WIDTH;

    logic [PsW-1:0]         ps_q, ps_d;
    logic                   tick;
    logic [NLines-1:0]      pins_n;
    logic [NLines-1:0]      stable_n;
    logic [15:0]            af_cnt_q, af_cnt_d;
    logic                   af_phase_q, af_phase_d;
    logic                   fire1, fire2, any_fire;
    logic [JOY_WIDTH-1:0]   port_a, port_b;
    logic [JOY_WIDTH-1:0]   joy1_q, joy1_d, joy2_q, joy2_d;
    logic                   changed_q, changed_d;

    assign tick = (ps_q == PsLast);
    assign ps_d = tick ? '0 : ps_q + PsW'(1);

    assign pins_n = {pins2_n_i, pins1_n_i};

    for (genvar i = 0; i < NLines; i++) begin : g_line
        joy_debounce_line #(
            .DebounceTicks(DebounceTicks)
        ) u_line (
            .clk_i     (clk_i),
            .rst_n     (rst_n),
            .tick_i    (tick),
            .pin_n_i   (pins_n[i]),
            .stable_n_o(stable_n[i])
        );
    end

    assign fire1    = ~stable_n[FirePos];
    assign fire2    = ~stable_n[JOY_WIDTH + FirePos];
    assign any_fire = fire1 | fire2;

    // Autofire timer idles with phase high so a fresh press shows up at once.
    always_comb begin
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (!any_fire) begin
            af_cnt_d   = '0;
            af_phase_d = 1'b1;
        end else if (tick) begin
            if (af_cnt_q == AfLast) begin
                af_cnt_d   = '0;
                af_phase_d = ~af_phase_q;
            end else begin
                af_cnt_d = af_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        port_a          = ~stable_n[JOY_WIDTH-1:0];
        port_b          = ~stable_n[NLines-1:JOY_WIDTH];
        port_a[FirePos] = fire1 & (af_phase_q | ~autofire_en_i);
        port_b[FirePos] = fire2 & (af_phase_q | ~autofire_en_i);
        joy1_d          = swap_i ? port_b : port_a;
        joy2_d          = swap_i ? port_a : port_b;
        changed_d       = (joy1_d != joy1_q) || (joy2_d != joy2_q);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ps_q       <= '0;
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
            joy1_q     <= '0;
            joy2_q     <= '0;
            changed_q  <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            changed_q  <= changed_d;
        end
    end

    assign joy1_o    = joy1_q;
    assign joy2_o    = joy2_q;
    assign changed_o = changed_q;

endmodule

// File: doc/joystick_conditioner.md
Name: joystick_conditioner

Overview:
- Conditions the raw Pmod joystick pins (JA/JB, active-low, asynchronous, bouncing) into clean active-high joystick vectors.
- Outputs feed mainboard joy1/joy2.
- Per line: 2-FF synchronizer, then a tick-based debouncer.
- Optional fire autofire and port swap; a one-cycle change strobe lets the service processor log input activity.

Parameters:
- prescale, 1074, clk cycles per debounce tick (about 10 us at the ~107.4 MHz system clock).
- debounce_ticks, 50, consecutive ticks a new level must persist before it is accepted (range 1..255).
- autofire_ticks, 3000, ticks per autofire half-period (range 1..65535).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pins1_n  in  5  raw port-1 pins, order [0:4] = fire, left, right, down, up; low = pressed
- pins2_n  in  5  raw port-2 pins, same order
- autofire_en  in  1  enables autofire on both fire lines; synchronous, quasi-static
- swap  in  1  exchanges ports 1 and 2 at the outputs; synchronous, quasi-static
- joy1  out  5  conditioned port 1 to mainboard, [0:4] same order, high = pressed
- joy2  out  5  conditioned port 2
- changed  out  1  one-cycle pulse when joy1 or joy2 differs from its previous-cycle value

Behaviour:
- Reset (rst_n low, asynchronous):
  - sync flops and stable levels = 1 (released); debounce counters = 0.
  - prescaler = 0; autofire counter = 0; autofire phase = 1.
  - joy1 = joy2 = 0; changed = 0.
  - Reset deasserting mid-bounce restarts all filtering from the released state.
- Synchronizer: two flops per line (10 lines). The raw pin is never used beyond the first flop.
- Prescaler: counts 0..prescale-1 and wraps. tick = 1 for the single cycle where the count is prescale-1. Free-running; shared by all lines and autofire.
- Debouncer, per line (states IDLE, PENDING):
  - IDLE, synced == stable: counter held at 0.
  - IDLE, synced != stable: go to PENDING with counter 0.
  - PENDING, synced == stable (bounce back): go to IDLE, counter 0.
  - PENDING, tick: counter increments. When the counter reaches debounce_ticks-1 on a tick, stable <= synced, counter <= 0, go to IDLE.
  - Counter is 8 bits and never wraps; it saturates at debounce_ticks-1.
  - A level held for at least debounce_ticks*prescale + 2 cycles is always accepted. A glitch shorter than prescale cycles is never accepted.
- Autofire:
  - Active when autofire_en = 1 and a port's stable fire is pressed.
  - The shared 16-bit autofire counter advances on tick while any fire line is pressed. On reaching autofire_ticks-1 it wraps to 0 and phase toggles.
  - When no fire is pressed, counter <= 0 and phase <= 1, so the first press is asserted immediately.
  - Effective fire = pressed AND (phase OR NOT autofire_en).
- Output stage (registered, 1 cycle after stable/phase):
  - a = ~stable1 with fire replaced by the effective fire; b likewise for port 2.
  - joy1 <= swap ? b : a; joy2 <= swap ? a : b.
- changed: registered compare of the new joy1/joy2 against their previous values. Asserted in the cycle after the outputs change, for exactly 1 cycle per change event. A swap toggle with differing ports also pulses changed.
- Simultaneous line changes are fully independent; no priority between lines.

Decomposition:
- Package joystick_pkg:
  - bit-index constants JOY_FIRE=0, JOY_LEFT=1, JOY_RIGHT=2, JOY_DOWN=3, JOY_UP=4
  - JOY_WIDTH=5
- Sub-module joy_debounce_line: one synchronizer plus debouncer. Ports: clk, rst_n, tick, pin_n, stable_n; parameter debounce_ticks. Instantiated 10 times.
- Prescaler, autofire and output stage live in the top.

Test Plan (prescale=4, debounce_ticks=3, autofire_ticks=2):
- Reset release with all pins high -> joy1=joy2=5'b00000 and changed=0 for 100 cycles.
- pins1_n[up] driven low and held -> joy1=5'b00001 within 3*4+4=16 cycles; changed pulses exactly once. Releasing it returns joy1=0 with a second single pulse.
- pins2_n[left] pulsed low for 3 cycles, repeated every 10 cycles for 5 bursts (bounce) -> joy2 stays 0 and changed never pulses.
- autofire_en=1, pins1_n[fire] held low -> joy1[fire] asserts within 16 cycles, then toggles every 8 cycles (2 ticks). Releasing it -> joy1[fire]=0 after debounce. Pressing again -> fire asserted on first output.
- pins1_n[right]=0 held, then swap raised -> next cycle joy1=0 and joy2=5'b00100, with changed pulsing once.
- rst_n pulsed low for 1 cycle while pins1_n[down] is pending, at count 1 -> outputs 0 immediately (asynchronously). After release, acceptance takes the full 3 ticks again.
